multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 mem_ready  input  1  memory has completed the current read or write this cycle.
REQ-006 pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write  output  1 each  PC, IR and memory strobes.
REQ-007 reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  datapath selects and the register-file write enable.
REQ-008 alu_src_b, alu_op, pc_source  output  2 each.
  - alu_src_b: 0=reg, 1=const 4, 2=signext, 3=signext<<2.
  - alu_op: 0=add, 1=sub, 2=funct.
  - pc_source: 0=ALU, 1=ALUOut, 2=jump target.
REQ-009 state  output  4  current FSM state, for debug.
REQ-010 retired_count  output  CNT_WIDTH  number of instructions completed.
REQ-011 illegal_op  output  1  sticky flag for an unsupported opcode.

Function
REQ-012 States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5
  - R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12
  - Codes 13-15 SHALL go to FETCH on the next edge.
REQ-013 FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - ir_write=pc_write=mem_ready (Mealy).
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-014 DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=0.
  - Next state by opcode:
    - 0x00 -> R_EXEC
    - 0x23 or 0x2B -> MEM_ADDR
    - 0x04 -> BRANCH
    - 0x02 -> JUMP
    - 0x08 -> I_EXEC
    - any other -> TRAP
REQ-015 MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=2, alu_op=0.
  - Next state: MEM_RD if opcode=0x23, MEM_WR if opcode=0x2B.
REQ-016 MEM_RD:
  - Outputs: mem_read=1, i_or_d=1.
  - Hold while mem_ready=0; go to MEM_WB when mem_ready=1.
REQ-017 MEM_WB:
  - Outputs: reg_write=1, mem_to_reg=1, reg_dst=0.
  - Next state: FETCH.
REQ-018 MEM_WR:
  - Outputs: mem_write=1 and i_or_d=1, both held until mem_ready=1.
  - Go to FETCH in the mem_ready=1 cycle.
REQ-019 R_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=2.
  - Next state: R_WB.
REQ-020 R_WB:
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
  - Next state: FETCH.
REQ-021 BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1.
  - Next state: FETCH.
REQ-022 JUMP:
  - Outputs: pc_write=1, pc_source=2.
  - Next state: FETCH.
REQ-023 I_EXEC:
  - Outputs: alu_src_a=1, alu_src_b=2, alu_op=0.
  - Next state: I_WB.
REQ-024 I_WB:
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
  - Next state: FETCH.
REQ-025 TRAP:
  - All strobes 0.
  - illegal_op set to 1.
  - Remain in TRAP until rst.
REQ-026 Any output not listed for a state SHALL be 0 in that state.
REQ-027 Strobes (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) SHALL never be asserted outside their listed states.
REQ-028 retired_count SHALL increment by 1 on each edge that leaves one of these states for FETCH:
  - MEM_WB
  - MEM_WR with mem_ready=1
  - R_WB
  - BRANCH
  - JUMP
  - I_WB
REQ-029 retired_count SHALL wrap from 2^CNT_WIDTH-1 to 0 and SHALL never saturate.
REQ-030 Instruction latency in cycles, with mem_ready tied to 1:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.

Reset
REQ-031 When rst=1 at a rising edge, state SHALL become FETCH, retired_count 0 and illegal_op 0.
REQ-032 While rst=1, all strobe outputs SHALL be forced to 0, regardless of state or mem_ready.
REQ-033 Reset mid-operation (including during a pending memory wait) SHALL abandon the instruction without retiring it.
REQ-034 After rst is released, FETCH SHALL begin in the first cycle with rst=0.

Verification
REQ-035 Reset, then opcode=0x00 with mem_ready=1 -> states 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; retired_count=1.
REQ-036 opcode=0x23 with mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles; mem_read=1 and i_or_d=1 throughout; MEM_WB reached next; retired_count +1 only on the MEM_WB->FETCH edge.
REQ-037 opcode=0x2B with mem_ready=0 for 2 cycles -> mem_write=1 for 3 cycles, then FETCH; no reg_write at any time.
REQ-038 opcode=0x3F -> DECODE then TRAP; illegal_op=1 and all strobes 0 for 10+ cycles; rst -> FETCH and illegal_op=0.
REQ-039 CNT_WIDTH=4, run 16 beq instructions -> retired_count reaches 15 then 0.
REQ-040 rst asserted in MEM_WR with mem_ready=0 -> mem_write=0 in the rst cycle, FETCH next, retired_count=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control unit.
// Walks each instruction through fetch, decode and the per-class execute,
// memory and write-back states, and drives the datapath selects and strobes.
//
// Ports:
//   clk            single clock, rising edge
//   rst            synchronous active-high reset
//   opcode[5:0]    instruction bits [31:26] from the instruction register
//   mem_ready      memory completed the current read/write this cycle
//   pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write
//                  PC, IR and memory strobes/selects
//   reg_dst, mem_to_reg, reg_write, alu_src_a
//                  datapath selects and register-file write enable
//   alu_src_b[1:0] 0=reg 1=const 4 2=signext 3=signext<<2
//   alu_op[1:0]    0=add 1=sub 2=funct
//   pc_source[1:0] 0=ALU 1=ALUOut 2=jump target
//   state[3:0]     current FSM state (debug)
//   retired_count  instructions completed, wraps
//   illegal_op     sticky flag, set on an unsupported opcode
module multicycle_controller #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic                 ir_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic [3:0]           state,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic                 illegal_op
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        R_EXEC   = 4'd6,
        R_WB     = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        I_EXEC   = 4'd10,
        I_WB     = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t state_q;
    state_t next_state;
    logic   retire;

    // State register, retire counter and sticky illegal flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FETCH;
            retired_count <= '0;
            illegal_op    <= 1'b0;
        end else begin
            state_q <= next_state;
            if (retire) begin
                retired_count <= retired_count + 1'b1;
            end
            if (next_state == TRAP) begin
                illegal_op <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_state = FETCH;
        retire     = 1'b0;
        case (state_q)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     next_state = R_EXEC;
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = I_EXEC;
                    default:      next_state = TRAP;
                endcase
            end
            // An opcode that changed under us after decode is treated as illegal
            MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    next_state = MEM_RD;
                end else if (opcode == OP_SW) begin
                    next_state = MEM_WR;
                end else begin
                    next_state = TRAP;
                end
            end
            MEM_RD:   next_state = mem_ready ? MEM_WB : MEM_RD;
            MEM_WB: begin
                next_state = FETCH;
                retire     = 1'b1;
            end
            MEM_WR: begin
                next_state = mem_ready ? FETCH : MEM_WR;
                retire     = mem_ready;
            end
            R_EXEC:   next_state = R_WB;
            R_WB, BRANCH, JUMP, I_WB: begin
                next_state = FETCH;
                retire     = 1'b1;
            end
            I_EXEC:   next_state = I_WB;
            TRAP:     next_state = TRAP;
            default:  next_state = FETCH;
        endcase
    end

    // Output logic; strobes are gated off while reset is asserted
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'd0;
        pc_source     = 2'd0;
        case (state_q)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            DECODE: begin
                alu_src_b = 2'd3;
            end
            MEM_ADDR, I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'd2;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'd1;
                pc_write_cond = 1'b1;
                pc_source     = 2'd1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
            end
            I_WB: begin
                reg_write = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            ir_write      = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            reg_write     = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller.
// A second instance with CNT_WIDTH=4 shares all inputs to exercise counter wrap.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;

    logic pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
    logic reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;
    logic [15:0] retired_count;
    logic illegal_op;

    logic w_pc_write, w_pc_write_cond, w_ir_write, w_i_or_d, w_mem_read, w_mem_write;
    logic w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;
    logic [3:0] w_state;
    logic [3:0] w_retired_count;
    logic w_illegal_op;

    // strobe vector: {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write}
    logic [5:0] strb;
    assign strb = {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write};

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .retired_count(retired_count),
        .illegal_op(illegal_op)
    );

    multicycle_controller #(.CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(w_pc_write), .pc_write_cond(w_pc_write_cond), .ir_write(w_ir_write),
        .i_or_d(w_i_or_d), .mem_read(w_mem_read), .mem_write(w_mem_write),
        .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write),
        .alu_src_a(w_alu_src_a), .alu_src_b(w_alu_src_b), .alu_op(w_alu_op),
        .pc_source(w_pc_source), .state(w_state), .retired_count(w_retired_count),
        .illegal_op(w_illegal_op)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_ready = 1'b1; opcode = 6'h00;
        cyc(); cyc();
        total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state); end
        total++; if (retired_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", retired_count); end
        total++; if (illegal_op !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", illegal_op); end
        total++; if (strb !== 6'b000000) begin bad++; $display("FAIL reset_strobes got=%b exp=000000", strb); end
        rst = 1'b0;
        #1;
        total++; if (strb !== 6'b101100 || alu_src_b !== 2'd1) begin bad++; $display("FAIL fetch_after_reset strb=%b srcb=%0d exp=101100/1", strb, alu_src_b); end
    endtask

    task automatic test_rtype();
        opcode = 6'h00; mem_ready = 1'b1;
        cyc();
        total++; if (state !== 4'd1 || alu_src_b !== 2'd3 || strb !== 6'b0) begin bad++; $display("FAIL r_decode state=%0d srcb=%0d strb=%b exp=1/3/0", state, alu_src_b, strb); end
        cyc();
        total++; if (state !== 4'd6 || alu_op !== 2'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0 || strb !== 6'b0) begin bad++; $display("FAIL r_exec state=%0d op=%0d a=%b strb=%b exp=6/2/1/0", state, alu_op, alu_src_a, strb); end
        cyc();
        total++; if (state !== 4'd7 || strb !== 6'b000001 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin bad++; $display("FAIL r_wb state=%0d strb=%b dst=%b exp=7/000001/1", state, strb, reg_dst); end
        total++; if (retired_count !== 16'(exp_cnt)) begin bad++; $display("FAIL r_wb_count got=%0d exp=%0d", retired_count, exp_cnt); end
        cyc(); exp_cnt++;
        total++; if (state !== 4'd0 || retired_count !== 16'(exp_cnt)) begin bad++; $display("FAIL r_retire state=%0d cnt=%0d exp=0/%0d", state, retired_count, exp_cnt); end
    endtask

    task automatic test_lw();
        opcode = 6'h23; mem_ready = 1'b1;
        cyc(); cyc();
        total++; if (state !== 4'd2 || alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || alu_op !== 2'd0 || strb !== 6'b0) begin bad++; $display("FAIL lw_addr state=%0d a=%b b=%0d strb=%b exp=2/1/2/0", state, alu_src_a, alu_src_b, strb); end
        mem_ready = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            total++; if (state !== 4'd3 || strb !== 6'b000100 || i_or_d !== 1'b1 || retired_count !== 16'(exp_cnt)) begin bad++; $display("FAIL lw_wait%0d state=%0d strb=%b iord=%b cnt=%0d exp=3/000100/1/%0d", i, state, strb, i_or_d, retired_count, exp_cnt); end
            cyc();
        end
        mem_ready = 1'b1;
        #1;
        total++; if (state !== 4'd3 || strb !== 6'b000100 || i_or_d !== 1'b1) begin bad++; $display("FAIL lw_ready state=%0d strb=%b exp=3/000100", state, strb); end
        cyc();
        total++; if (state !== 4'd4 || strb !== 6'b000001 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0 || retired_count !== 16'(exp_cnt)) begin bad++; $display("FAIL lw_wb state=%0d strb=%b m2r=%b cnt=%0d exp=4/000001/1/%0d", state, strb, mem_to_reg, retired_count, exp_cnt); end
        cyc(); exp_cnt++;
        total++; if (state !== 4'd0 || retired_count !== 16'(exp_cnt)) begin bad++; $display("FAIL lw_retire state=%0d cnt=%0d exp=0/%0d", state, retired_count, exp_cnt); end
    endtask

    task automatic test_sw();
        int writes = 0;
        int regw = 0;
        opcode = 6'h2B; mem_ready = 1'b1;
        regw += int'(reg_write);
        cyc(); regw += int'(reg_write);
        cyc(); regw += int'(reg_write);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) mem_ready = 1'b1;
            #1;
            writes += int'(mem_write);
            regw += int'(reg_write);
            total++; if (state !== 4'd5 || i_or_d !== 1'b1 || retired_count !== 16'(exp_cnt)) begin bad++; $display("FAIL sw_wr%0d state=%0d iord=%b cnt=%0d exp=5/1/%0d", i, state, i_or_d, retired_count, exp_cnt); end
        end
        cyc(); exp_cnt++;
        total++; if (writes != 3 || regw != 0) begin bad++; $display("FAIL sw_strobes mem_write_cycles=%0d reg_write_cycles=%0d exp=3/0", writes, regw); end
        total++; if (state !== 4'd0 || retired_count !== 16'(exp_cnt)) begin bad++; $display("FAIL sw_retire state=%0d cnt=%0d exp=0/%0d", state, retired_count, exp_cnt); end
    endtask

    task automatic test_addi();
        opcode = 6'h08; mem_ready = 1'b1;
        cyc(); cyc();
        total++; if (state !== 4'd10 || alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || strb !== 6'b0) begin bad++; $display("FAIL addi_exec state=%0d a=%b b=%0d strb=%b exp=10/1/2/0", state, alu_src_a, alu_src_b, strb); end
        cyc();
        total++; if (state !== 4'd11 || strb !== 6'b000001 || reg_dst !== 1'b0 || mem_to_reg !== 1'b0) begin bad++; $display("FAIL addi_wb state=%0d strb=%b dst=%b m2r=%b exp=11/000001/0/0", state, strb, reg_dst, mem_to_reg); end
        cyc(); exp_cnt++;
        total++; if (state !== 4'd0 || retired_count !== 16'(exp_cnt)) begin bad++; $display("FAIL addi_retire state=%0d cnt=%0d exp=0/%0d", state, retired_count, exp_cnt); end
    endtask

    task automatic test_trap();
        opcode = 6'h3F; mem_ready = 1'b1;
        cyc();
        total++; if (state !== 4'd1 || illegal_op !== 1'b0) begin bad++; $display("FAIL trap_decode state=%0d ill=%b exp=1/0", state, illegal_op); end
        cyc();
        for (int i = 0; i < 12; i++) begin
            mem_ready = i[0];
            #1;
            total++; if (state !== 4'd12 || illegal_op !== 1'b1 || strb !== 6'b0 || retired_count !== 16'(exp_cnt)) begin bad++; $display("FAIL trap_hold%0d state=%0d ill=%b strb=%b cnt=%0d exp=12/1/0/%0d", i, state, illegal_op, strb, retired_count, exp_cnt); end
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0; mem_ready = 1'b1; exp_cnt = 0;
        #1;
        total++; if (state !== 4'd0 || illegal_op !== 1'b0 || retired_count !== 16'd0) begin bad++; $display("FAIL trap_reset state=%0d ill=%b cnt=%0d exp=0/0/0", state, illegal_op, retired_count); end
    endtask

    task automatic test_reset_in_memwr();
        opcode = 6'h02; mem_ready = 1'b1;
        cyc(); cyc();
        total++; if (state !== 4'd9 || strb !== 6'b100000 || pc_source !== 2'd2) begin bad++; $display("FAIL jump state=%0d strb=%b src=%0d exp=9/100000/2", state, strb, pc_source); end
        cyc(); exp_cnt++;
        total++; if (state !== 4'd0 || retired_count !== 16'(exp_cnt)) begin bad++; $display("FAIL jump_retire state=%0d cnt=%0d exp=0/%0d", state, retired_count, exp_cnt); end
        opcode = 6'h2B;
        cyc(); cyc();
        mem_ready = 1'b0;
        cyc();
        total++; if (state !== 4'd5 || mem_write !== 1'b1) begin bad++; $display("FAIL memwr_pending state=%0d mw=%b exp=5/1", state, mem_write); end
        rst = 1'b1;
        #1;
        total++; if (state !== 4'd5 || strb !== 6'b0) begin bad++; $display("FAIL memwr_rst_gate state=%0d strb=%b exp=5/000000", state, strb); end
        cyc(); exp_cnt = 0;
        total++; if (state !== 4'd0 || retired_count !== 16'd0 || w_retired_count !== 4'd0) begin bad++; $display("FAIL memwr_abandon state=%0d cnt=%0d cnt4=%0d exp=0/0/0", state, retired_count, w_retired_count); end
        rst = 1'b0; mem_ready = 1'b1;
        #1;
        total++; if (state !== 4'd0 || strb !== 6'b101100) begin bad++; $display("FAIL memwr_refetch state=%0d strb=%b exp=0/101100", state, strb); end
    endtask

    task automatic test_beq_wrap();
        opcode = 6'h04; mem_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc(); cyc();
            if (i == 0) begin
                total++; if (state !== 4'd8 || strb !== 6'b010000 || pc_source !== 2'd1 || alu_op !== 2'd1 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0) begin bad++; $display("FAIL beq state=%0d strb=%b src=%0d op=%0d exp=8/010000/1/1", state, strb, pc_source, alu_op); end
            end
            cyc(); exp_cnt++;
            if (i == 14) begin
                total++; if (w_retired_count !== 4'd15) begin bad++; $display("FAIL wrap_max got=%0d exp=15", w_retired_count); end
            end
        end
        total++; if (w_retired_count !== 4'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", w_retired_count); end
        total++; if (retired_count !== 16'(exp_cnt) || state !== 4'd0) begin bad++; $display("FAIL beq_count16 cnt=%0d state=%0d exp=%0d/0", retired_count, state, exp_cnt); end
    endtask

    initial begin
        rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0;
        test_reset();
        test_rtype();
        test_lw();
        test_sw();
        test_addi();
        test_trap();
        test_reset_in_memwr();
        test_beq_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
